// File: rtl/systolic_result_serializer.sv
// systolic_result_serializer
//   Captures the N x N 32-bit result matrix from the systolic array when the
//   valid-result pulse arrives. It then drains the matrix as a valid/ready
//   stream in row-major order, one element per beat, with row/col tags and a
//   last flag.
//
//   Optional feature macro: SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
//     This macro adds a pending matrix buffer, so that a second result can be
//     queued while the current one streams out.
//
// Ports
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_c            result matrix, sampled only when i_validResult=1
//   i_validResult  single-cycle pulse marking i_c valid
//   i_clrOverflow  clears o_overflow (a new drop in the same cycle wins)
//   o_data         current element C[o_row][o_col]
//   o_row, o_col   element indices
//   o_valid        beat valid
//   i_ready        consumer accepts the beat
//   o_last         beat carries (N-1,N-1)
//   o_busy         streaming, or pending buffer occupied
//   o_overflow     sticky: a result pulse was dropped
module systolic_result_serializer #(
   parameter int N = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N-1:0][N-1:0][31:0]     i_c,
   input  logic                          i_validResult,
   input  logic                          i_clrOverflow,
   output logic [31:0]                   o_data,
   output logic [$clog2(N)-1:0]          o_row,
   output logic [$clog2(N)-1:0]          o_col,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic                          o_last,
   output logic                          o_busy,
   output logic                          o_overflow
);

   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

   generate
      if (N < 3 || N > 256) begin : gen_bad_n
         $error("systolic_result_serializer: N must satisfy 2 < N < 257");
      end
   endgenerate

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  row_reg;
   logic [IDX_W-1:0]  col_reg;
   logic              ovf_reg;
   logic [31:0]       act_mem [N][N];

   logic xfer;
   logic last_pos;
   logic act_load;       // active buffer takes i_c
   logic drop;           // pulse cannot be stored anywhere

`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
   logic [31:0]       pend_mem [N][N];
   logic              pend_full_reg;
   logic              pend_load;       // pending buffer takes i_c
   logic              act_from_pend;   // pending buffer promoted to active
`endif

   assign xfer     = (state_reg == STREAM) && i_ready;
   assign last_pos = (row_reg == IDX_MAX) && (col_reg == IDX_MAX);

   always_comb begin
      act_load = 1'b0;
      drop     = 1'b0;
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
      pend_load     = 1'b0;
      act_from_pend = 1'b0;
`endif
      if (state_reg == IDLE) begin
         act_load = i_validResult;
      end else if (xfer && last_pos) begin
         // The last beat frees the active buffer, so a pulse in this cycle
         // is never an overflow.
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
         if (pend_full_reg) begin
            act_from_pend = 1'b1;
            pend_load     = i_validResult;
         end else begin
            act_load = i_validResult;
         end
`else
         act_load = i_validResult;
`endif
      end else if (i_validResult) begin
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
         if (!pend_full_reg) pend_load = 1'b1;
         else                drop      = 1'b1;
`else
         drop = 1'b1;
`endif
      end
   end

   // Control FSM
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         row_reg   <= '0;
         col_reg   <= '0;
         ovf_reg   <= 1'b0;
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
         pend_full_reg <= 1'b0;
`endif
      end else begin
         if (drop)               ovf_reg <= 1'b1;
         else if (i_clrOverflow) ovf_reg <= 1'b0;

`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
         if (pend_load)          pend_full_reg <= 1'b1;
         else if (act_from_pend) pend_full_reg <= 1'b0;
`endif

         case (state_reg)
            IDLE: begin
               if (act_load) begin
                  state_reg <= STREAM;
                  row_reg   <= '0;
                  col_reg   <= '0;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (last_pos) begin
                     row_reg <= '0;
                     col_reg <= '0;
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
                     if (!(act_load || act_from_pend)) state_reg <= IDLE;
`else
                     if (!act_load) state_reg <= IDLE;
`endif
                  end else if (col_reg == IDX_MAX) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 1'b1;
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Matrix storage; the whole matrix loads in one cycle.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (act_load) act_mem[i][j] <= i_c[i][j];
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
            else if (act_from_pend) act_mem[i][j] <= pend_mem[i][j];
            if (pend_load) pend_mem[i][j] <= i_c[i][j];
`endif
         end
      end
   end

   assign o_valid    = (state_reg == STREAM);
   // Storage is not reset, so gate the mux to keep o_data at zero when idle.
   assign o_data     = o_valid ? act_mem[row_reg][col_reg] : 32'd0;
   assign o_row      = row_reg;
   assign o_col      = col_reg;
   assign o_last     = o_valid && last_pos;
   assign o_overflow = ovf_reg;
`ifdef SYSTOLIC_RESULT_SERIALIZER_DOUBLE_BUFFER_EN
   assign o_busy     = o_valid || pend_full_reg;
`else
   assign o_busy     = o_valid;
`endif

endmodule
